// File: rtl/dm_boot_loader_if.sv
// Bus bundle between the boot loader and its neighbours: boot byte stream,
// CPU-side data-memory port, and the physical data-memory port.
interface dm_boot_loader_if #(
  parameter int WL = 32,
  parameter int AW = 9
);
  logic          in_valid;
  logic [7:0]    in_data;
  logic          in_ready;
  logic          reload;
  logic          cpu_run;
  logic          cpu_dmwe;
  logic [AW-1:0] cpu_dma;
  logic [WL-1:0] cpu_dmwd;
  logic [WL-1:0] cpu_dmrd;
  logic          dmwe;
  logic [AW-1:0] dma;
  logic [WL-1:0] dmwd;
  logic [WL-1:0] dmrd;

  modport slave (
    input  in_valid, in_data, reload, cpu_dmwe, cpu_dma, cpu_dmwd, dmrd,
    output in_ready, cpu_run, cpu_dmrd, dmwe, dma, dmwd
  );

  modport master (
    output in_valid, in_data, reload, cpu_dmwe, cpu_dma, cpu_dmwd, dmrd,
    input  in_ready, cpu_run, cpu_dmrd, dmwe, dma, dmwd
  );
endinterface

// File: rtl/dm_boot_loader.sv
// Owns the data-memory port: packs a big-endian byte stream into words at
// addresses 0..NWORDS-1 while the CPU is held, then passes the port through.
module dm_boot_loader #(
  parameter int WL     = 32,
  parameter int AW     = 9,
  parameter int NWORDS = 64
) (
  input logic             clk,
  input logic             rst,
  dm_boot_loader_if.slave bus
);

  localparam int BPW = WL / 8;
  localparam int CW  = (BPW > 1) ? $clog2(BPW) : 1;

  localparam logic [1:0] ST_LOAD  = 2'd0;
  localparam logic [1:0] ST_WRITE = 2'd1;
  localparam logic [1:0] ST_DONE  = 2'd2;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] byte_cnt_q, byte_cnt_d;
  logic [AW:0]   word_addr_q, word_addr_d;
  logic [WL-1:0] sreg_q, sreg_d;
  logic          accept;
  logic [AW:0]   word_addr_inc;

  assign accept        = bus.in_valid && (state_q == ST_LOAD);
  assign word_addr_inc = word_addr_q + (AW+1)'(1);

  always_comb begin
    state_d     = state_q;
    byte_cnt_d  = byte_cnt_q;
    word_addr_d = word_addr_q;
    sreg_d      = sreg_q;
    case (state_q)
      ST_LOAD: begin
        if (accept) begin
          sreg_d = (sreg_q << 8) | WL'(bus.in_data);
          if (byte_cnt_q == CW'(BPW - 1)) begin
            byte_cnt_d = '0;
            state_d    = ST_WRITE;
          end else begin
            byte_cnt_d = byte_cnt_q + CW'(1);
          end
        end
      end
      ST_WRITE: begin
        // word_addr saturates at NWORDS because DONE is entered exactly there
        word_addr_d = word_addr_inc;
        state_d     = (word_addr_inc == (AW+1)'(NWORDS)) ? ST_DONE : ST_LOAD;
      end
      ST_DONE: begin
        if (bus.reload) begin
          state_d     = ST_LOAD;
          word_addr_d = '0;
          byte_cnt_d  = '0;
        end
      end
      default: begin
        state_d = ST_LOAD;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= ST_LOAD;
      byte_cnt_q  <= '0;
      word_addr_q <= '0;
      sreg_q      <= '0;
    end else begin
      state_q     <= state_d;
      byte_cnt_q  <= byte_cnt_d;
      word_addr_q <= word_addr_d;
      sreg_q      <= sreg_d;
    end
  end

  // The DM port belongs to the loader until DONE, then to the datapath.
  always_comb begin
    bus.in_ready = (state_q == ST_LOAD);
    bus.cpu_run  = (state_q == ST_DONE);
    if (state_q == ST_DONE) begin
      bus.dmwe     = bus.cpu_dmwe;
      bus.dma      = bus.cpu_dma;
      bus.dmwd     = bus.cpu_dmwd;
      bus.cpu_dmrd = bus.dmrd;
    end else begin
      bus.dmwe     = (state_q == ST_WRITE);
      bus.dma      = word_addr_q[AW-1:0];
      bus.dmwd     = sreg_q;
      bus.cpu_dmrd = '0;
    end
  end

endmodule

// File: tb/tb_dm_boot_loader.sv
// Randomized scoreboard bench for dm_boot_loader: a byte-list model predicts
// every DM write; a negedge monitor pops and compares each observed write.
module tb_dm_boot_loader;

  localparam int WL     = 32;
  localparam int AW     = 9;
  localparam int NWORDS = 4;
  localparam int BPW    = WL / 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WL-1:0] data;
  } wr_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  always #5 clk = ~clk;

  dm_boot_loader_if #(.WL(WL), .AW(AW)) bus ();

  dm_boot_loader #(.WL(WL), .AW(AW), .NWORDS(NWORDS)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  wr_t         expq[$];
  byte unsigned part[$];
  int          m_words  = 0;
  int          n_checks = 0;
  int          n_fail   = 0;

  task automatic check_output(input string name, input logic [63:0] act, input logic [63:0] req);
    n_checks++;
    if (act !== req) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0h, required %0h", name, act, req);
    end
  endtask

  // Reference model: collect bytes, emit one big-endian word per BPW bytes
  function automatic void model_reset();
    part.delete();
    m_words = 0;
  endfunction

  function automatic void model_byte(input byte unsigned b);
    logic [WL-1:0] w;
    wr_t           e;
    part.push_back(b);
    if (part.size() == BPW) begin
      w = '0;
      foreach (part[i]) w = (w << 8) | WL'(part[i]);
      e.addr = AW'(m_words);
      e.data = w;
      expq.push_back(e);
      m_words++;
      part.delete();
    end
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // CPU-side and reload noise while loading must never reach the DM port
  task automatic noise();
    if (m_words < NWORDS) begin
      bus.cpu_dmwe = 1'($urandom_range(0, 1));
      bus.cpu_dma  = AW'($urandom);
      bus.cpu_dmwd = $urandom;
      bus.reload   = ($urandom_range(0, 7) == 0);
    end else begin
      bus.cpu_dmwe = 1'b0;
      bus.reload   = 1'b0;
    end
    bus.dmrd = $urandom;
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      tick();
      noise();
    end
  endtask

  task automatic send_byte(input byte unsigned b);
    int guard = 0;
    bus.in_valid = 1'b1;
    bus.in_data  = b;
    noise();
    while (!bus.in_ready && guard < 20) begin
      tick();
      noise();
      guard++;
    end
    if (guard >= 20) check_output("in_ready_timeout", 64'(guard), 64'd0);
    check_output("cpu_run_hold", bus.cpu_run, 1'b0);
    check_output("cpu_dmrd_hold", bus.cpu_dmrd, '0);
    model_byte(b);
    tick();
    bus.in_valid = 1'b0;
    bus.in_data  = 8'($urandom);
    noise();
  endtask

  task automatic do_reset();
    rst = 1'b1;
    model_reset();
    bus.in_valid = 1'b0;
    noise();
    #1;
    check_output("rst_in_ready", bus.in_ready, 1'b1);
    check_output("rst_cpu_run", bus.cpu_run, 1'b0);
    check_output("rst_dmwe", bus.dmwe, 1'b0);
    check_output("rst_dma", bus.dma, '0);
    check_output("rst_dmwd", bus.dmwd, '0);
    check_output("rst_cpu_dmrd", bus.cpu_dmrd, '0);
    tick();
    noise();
    tick();
    rst = 1'b0;
  endtask

  // One cycle of datapath traffic while the loader is known to be in DONE
  task automatic cpu_cycle(input logic we, input logic [AW-1:0] a, input logic [WL-1:0] d,
                           input logic rl, input logic [WL-1:0] rd);
    wr_t e;
    bus.cpu_dmwe = we;
    bus.cpu_dma  = a;
    bus.cpu_dmwd = d;
    bus.reload   = rl;
    bus.dmrd     = rd;
    bus.in_valid = 1'($urandom_range(0, 1));
    bus.in_data  = 8'($urandom);
    if (we) begin
      e.addr = a;
      e.data = d;
      expq.push_back(e);
    end
    #1;
    check_output("done_cpu_run", bus.cpu_run, 1'b1);
    check_output("done_in_ready", bus.in_ready, 1'b0);
    check_output("done_dmwe", bus.dmwe, we);
    check_output("done_dma", bus.dma, a);
    check_output("done_dmwd", bus.dmwd, d);
    check_output("done_cpu_dmrd", bus.cpu_dmrd, rd);
    tick();
    if (rl) model_reset();
    bus.reload   = 1'b0;
    bus.cpu_dmwe = 1'b0;
    bus.in_valid = 1'b0;
  endtask

  // Monitor: every DM write must match the oldest predicted write
  initial begin
    wr_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.dmwe) begin
        if (expq.size() == 0) begin
          n_checks++;
          n_fail++;
          $display("[TB] FAIL unexpected_dm_write: dmwe=1 at dma=%0h dmwd=%0h, required dmwe=0",
                   bus.dma, bus.dmwd);
        end else begin
          e = expq.pop_front();
          check_output("dm_write_addr", bus.dma, e.addr);
          check_output("dm_write_data", bus.dmwd, e.data);
        end
      end
    end
  end

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    byte unsigned seq[$];
    bus.in_valid = 1'b0;
    bus.in_data  = '0;
    bus.reload   = 1'b0;
    bus.cpu_dmwe = 1'b0;
    bus.cpu_dma  = '0;
    bus.cpu_dmwd = '0;
    bus.dmrd     = '0;

    // Back-to-back word, then check WRITE-cycle timing
    do_reset();
    seq = '{8'h11, 8'h22, 8'h33, 8'h44};
    foreach (seq[i]) send_byte(seq[i]);
    check_output("t1_in_ready_write", bus.in_ready, 1'b0);
    check_output("t1_dmwe", bus.dmwe, 1'b1);
    check_output("t1_dma", bus.dma, 9'd0);
    check_output("t1_dmwd", bus.dmwd, 32'h11223344);
    tick();
    check_output("t1_in_ready_after", bus.in_ready, 1'b1);
    check_output("t1_dmwe_after", bus.dmwe, 1'b0);

    // Gapped stream: two idle cycles between bytes
    do_reset();
    seq = '{8'hAA, 8'hBB, 8'hCC, 8'hDD};
    foreach (seq[i]) begin
      send_byte(seq[i]);
      idle(2);
    end

    // Full load of NWORDS words, CPU_RUN timing, pass-through read
    do_reset();
    for (int i = 0; i < NWORDS * BPW; i++) send_byte(8'(i));
    check_output("t3_cpu_run_in_write", bus.cpu_run, 1'b0);
    tick();
    check_output("t3_cpu_run_rise", bus.cpu_run, 1'b1);
    cpu_cycle(1'b0, 9'd2, $urandom, 1'b0, 32'd5);

    // Reload with a same-cycle CPU store
    cpu_cycle(1'b1, 9'd7, $urandom, 1'b1, $urandom);
    check_output("t5_cpu_run_after_reload", bus.cpu_run, 1'b0);
    check_output("t5_in_ready_after_reload", bus.in_ready, 1'b1);
    bus.cpu_dmwe = 1'b1;
    bus.cpu_dma  = 9'd7;
    #1;
    check_output("t5_cpu_store_blocked", bus.dmwe, 1'b0);
    tick();
    bus.cpu_dmwe = 1'b0;

    // Reload mid-word is ignored
    send_byte(8'h5A);
    send_byte(8'hA5);
    bus.reload = 1'b1;
    tick();
    bus.reload = 1'b0;
    send_byte(8'h3C);
    send_byte(8'hC3);
    idle(2);

    // Reset after six bytes discards the partial word
    send_byte(8'h77);
    send_byte(8'h88);
    do_reset();
    seq = '{8'h01, 8'h02, 8'h03, 8'h04};
    foreach (seq[i]) send_byte(seq[i]);
    idle(2);
    while (m_words < NWORDS) send_byte(8'($urandom));
    tick();

    // Randomized reload / load / run rounds
    for (int r = 0; r < 3; r++) begin
      cpu_cycle(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 1'b1, $urandom);
      for (int i = 0; i < NWORDS * BPW; i++) begin
        send_byte(8'($urandom));
        idle($urandom_range(0, 2));
      end
      if (bus.cpu_run !== 1'b1) tick();
      for (int k = 0; k < 6; k++)
        cpu_cycle(1'($urandom_range(0, 1)), AW'($urandom), $urandom, 1'b0, $urandom);
    end

    idle(3);
    check_output("pending_writes", 64'(expq.size()), 64'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
